// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared FSM state type and width default for the GCD engine
package gcd_pkg;

   localparam int GCD_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } gcd_state_t;

endpackage

// File: rtl/gcd_sub_cmp.sv
// rtl/gcd_sub_cmp.sv - magnitude compare and larger-minus-smaller difference
module gcd_sub_cmp #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic             lt,
   output logic             eq,
   output logic [WIDTH-1:0] diff
);

   // Flags and a single subtractor whose operand order follows the compare,
   // so the difference can never underflow.
   always_comb begin
      gt   = (a > b);
      lt   = (a < b);
      eq   = (a == b);
      diff = gt ? (a - b) : (b - a);
   end

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - subtractive GCD engine; optional iter_count output under GCD_ITER_COUNT_EN
module gcd_engine
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero_err
`ifdef GCD_ITER_COUNT_EN
   ,output logic [WIDTH-1:0] iter_count
`endif
);

   gcd_state_t state, state_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             a_gt_b;
   logic             a_lt_b;
   logic             a_eq_b;
   logic [WIDTH-1:0] diff;
   logic             a_zero;
   logic             b_zero;
   logic             finish;

`ifdef GCD_ITER_COUNT_EN
   logic [WIDTH-1:0] cnt;
`endif

   gcd_sub_cmp #(
      .WIDTH (WIDTH)
   ) u_sub_cmp (
      .a    (a_reg),
      .b    (b_reg),
      .gt   (a_gt_b),
      .lt   (a_lt_b),
      .eq   (a_eq_b),
      .diff (diff)
   );

   // Termination test: either operand exhausted, or both equal.
   always_comb begin
      a_zero = (a_reg == '0);
      b_zero = (b_reg == '0);
      finish = a_zero || b_zero || a_eq_b;
   end

   // State register; reset wins over any activity.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; start is only looked at while idle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CALC;
         CALC:    if (finish) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      ready = (state == IDLE);
      done  = (state == DONE);
   end

   // Datapath: capture operands, one subtraction per CALC cycle, latch result.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         result     <= '0;
         zero_err   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
         cnt        <= '0;
         iter_count <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= a_in;
                  b_reg <= b_in;
`ifdef GCD_ITER_COUNT_EN
                  cnt   <= '0;
`endif
               end
            end
            CALC: begin
               if (a_zero || b_zero) begin
                  result     <= a_reg | b_reg;
                  zero_err   <= a_zero && b_zero;
`ifdef GCD_ITER_COUNT_EN
                  iter_count <= cnt;
`endif
               end else if (a_eq_b) begin
                  result     <= a_reg;
                  zero_err   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
                  iter_count <= cnt;
`endif
               end else if (a_gt_b) begin
                  a_reg <= diff;
`ifdef GCD_ITER_COUNT_EN
                  cnt   <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
`endif
               end else if (a_lt_b) begin
                  b_reg <= diff;
`ifdef GCD_ITER_COUNT_EN
                  cnt   <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
